// File: rtl/ltpi_pkg.sv
// ----------------------------------------------------------------------------
// ltpi_pkg
// Shared LTPI types and constants.
//   LTPI_base_Frm_t : 15-byte base frame, serialised by ltpi_phy_tx at byte
//                     offsets 0..14 (offset 15 is the inter-frame slot).
//   frm_src_t       : which source currently drives ltpi_frame_tx.
//   sched_state_t   : frame scheduler link state.
// ----------------------------------------------------------------------------
package ltpi_pkg;

    typedef struct packed {
        logic [7:0]        comma_symbol;
        logic [7:0]        frame_subtype;
        logic [7:0]        frame_counter;
        logic [11:0][7:0]  payload;
    } LTPI_base_Frm_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_TRN  = 2'd1,
        SRC_DFLT = 2'd2,
        SRC_DATA = 2'd3
    } frm_src_t;

    typedef enum logic [1:0] {
        WAIT_SYNC   = 2'd0,
        TRAINING    = 2'd1,
        OPERATIONAL = 2'd2
    } sched_state_t;

    // Offset at which the PHY is between frames; entering it marks a boundary.
    localparam logic [3:0] FRM_LAST_OFFSET = 4'hF;

endpackage : ltpi_pkg

// File: rtl/ltpi_tx_frm_scheduler.sv
// ----------------------------------------------------------------------------
// ltpi_tx_frm_scheduler
// Chooses, once per LTPI frame, which source frame feeds ltpi_phy_tx:
// training, default operational I/O, or a data-channel frame. The choice is
// made on entry into offset 15 and registered, so ltpi_frame_tx is stable
// while the PHY serialises offsets 0..14 of the following frame.
//
// Ports:
//   clk, reset        : clock (shared with ltpi_phy_tx), sync active-high reset
//   tx_frm_offset     : current byte offset reported by ltpi_phy_tx
//   link_op           : 1 = operational, 0 = training (sampled at boundary)
//   trn_frm/dflt_frm  : training / default I/O frame contents
//   data_frm(_req)    : data-channel frame and level request
//   data_frm_ack      : one-cycle pulse, data_frm has been latched
//   ltpi_frame_tx     : frame handed to ltpi_phy_tx
//   frm_src           : source of ltpi_frame_tx
//   frm_tick          : one-cycle pulse per boundary taken
//   tx_frm_cnt        : boundaries taken since reset (wraps)
// ----------------------------------------------------------------------------
module ltpi_tx_frm_scheduler
    import ltpi_pkg::*;
#(
    parameter int unsigned MAX_CONSEC_DATA = 4,   // legal 1..15
    parameter int unsigned CNT_W           = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           tx_frm_offset,
    input  logic                 link_op,
    input  LTPI_base_Frm_t       trn_frm,
    input  LTPI_base_Frm_t       dflt_frm,
    input  LTPI_base_Frm_t       data_frm,
    input  logic                 data_frm_req,
    output logic                 data_frm_ack,
    output LTPI_base_Frm_t       ltpi_frame_tx,
    output frm_src_t             frm_src,
    output logic                 frm_tick,
    output logic [CNT_W-1:0]     tx_frm_cnt
);

    localparam logic [3:0] MAX_CONSEC = 4'(MAX_CONSEC_DATA);

    sched_state_t       state_q,   state_d;
    logic [3:0]         offs_q;
    logic [3:0]         consec_q,  consec_d;
    LTPI_base_Frm_t     frame_q,   frame_d;
    frm_src_t           src_q,     src_d;
    logic               ack_q,     ack_d;
    logic               tick_q,    tick_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;

    logic               bnd;
    logic               take_trn;
    logic               take_op;

    // offs_q resets to F so a reset released during offset 15 waits for the
    // next real entry into 15 instead of firing a spurious boundary.
    assign bnd = (tx_frm_offset == FRM_LAST_OFFSET) && (offs_q != FRM_LAST_OFFSET);

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d  = state_q;
        consec_d = consec_q;
        frame_d  = frame_q;
        src_d    = src_q;
        ack_d    = 1'b0;
        tick_d   = 1'b0;
        cnt_d    = cnt_q;
        take_trn = 1'b0;
        take_op  = 1'b0;

        // State moves and the frame decision happen only at a boundary;
        // link_op is ignored everywhere else.
        if (bnd) begin
            tick_d = 1'b1;
            cnt_d  = cnt_q + CNT_W'(1);
            unique case (state_q)
                WAIT_SYNC, TRAINING: begin
                    if (link_op) begin
                        state_d = OPERATIONAL;
                        take_op = 1'b1;
                    end else begin
                        state_d  = TRAINING;
                        take_trn = 1'b1;
                    end
                end
                OPERATIONAL: begin
                    if (!link_op) begin
                        state_d  = TRAINING;
                        take_trn = 1'b1;
                    end else begin
                        take_op = 1'b1;
                    end
                end
                default: state_d = WAIT_SYNC;
            endcase
        end

        if (take_trn) begin
            frame_d  = trn_frm;
            src_d    = SRC_TRN;
            consec_d = 4'd0;
        end

        // Starvation guard: after MAX_CONSEC back-to-back data frames one
        // default frame is forced, which also clears the run length.
        if (take_op) begin
            if (data_frm_req && (consec_q < MAX_CONSEC)) begin
                frame_d  = data_frm;
                src_d    = SRC_DATA;
                ack_d    = 1'b1;
                consec_d = consec_q + 4'd1;
            end else begin
                frame_d  = dflt_frm;
                src_d    = SRC_DFLT;
                consec_d = 4'd0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= WAIT_SYNC;
            offs_q   <= FRM_LAST_OFFSET;
            consec_q <= 4'd0;
            frame_q  <= '0;
            src_q    <= SRC_NONE;
            ack_q    <= 1'b0;
            tick_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            offs_q   <= tx_frm_offset;
            consec_q <= consec_d;
            frame_q  <= frame_d;
            src_q    <= src_d;
            ack_q    <= ack_d;
            tick_q   <= tick_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ltpi_frame_tx = frame_q;
    assign frm_src       = src_q;
    assign data_frm_ack  = ack_q;
    assign frm_tick      = tick_q;
    assign tx_frm_cnt    = cnt_q;

endmodule : ltpi_tx_frm_scheduler

// File: tb/tb_ltpi_tx_frm_scheduler.sv
// ----------------------------------------------------------------------------
// tb_ltpi_tx_frm_scheduler
// Randomised bench with a frame-level reference model. Inputs change on the
// falling edge; DUT outputs are compared against the model on the falling
// edge, before new stimulus is applied.
// ----------------------------------------------------------------------------
module tb_ltpi_tx_frm_scheduler;
    import ltpi_pkg::*;

    localparam int MAX_CONSEC_DATA = 4;
    localparam int CNT_W           = 8;   // short counter so wrap is reachable

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [3:0]         tx_off = 4'd0;
    logic               link_op = 1'b0;
    LTPI_base_Frm_t     trn_frm = '0;
    LTPI_base_Frm_t     dflt_frm = '0;
    LTPI_base_Frm_t     data_frm = '0;
    logic               req = 1'b0;
    logic               ack;
    LTPI_base_Frm_t     frame_tx;
    frm_src_t           src;
    logic               tick;
    logic [CNT_W-1:0]   cnt;

    ltpi_tx_frm_scheduler #(
        .MAX_CONSEC_DATA (MAX_CONSEC_DATA),
        .CNT_W           (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tx_frm_offset (tx_off),
        .link_op       (link_op),
        .trn_frm       (trn_frm),
        .dflt_frm      (dflt_frm),
        .data_frm      (data_frm),
        .data_frm_req  (req),
        .data_frm_ack  (ack),
        .ltpi_frame_tx (frame_tx),
        .frm_src       (src),
        .frm_tick      (tick),
        .tx_frm_cnt    (cnt)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // At each entry into offset 15: training frame if the link is down;
    // otherwise a data frame if requested and fewer than MAX_CONSEC_DATA
    // data frames were just sent in a row, else the default frame.
    LTPI_base_Frm_t m_frame = '0;
    frm_src_t       m_src   = SRC_NONE;
    logic           m_ack   = 1'b0;
    logic           m_tick  = 1'b0;
    int             m_cnt   = 0;
    int             m_run   = 0;
    int             m_prev  = 15;

    always @(posedge clk) begin
        if (reset) begin
            m_frame = '0; m_src = SRC_NONE; m_ack = 1'b0; m_tick = 1'b0;
            m_cnt = 0; m_run = 0; m_prev = 15;
        end else begin
            m_ack  = 1'b0;
            m_tick = 1'b0;
            if (int'(tx_off) == 15 && m_prev != 15) begin
                m_tick = 1'b1;
                m_cnt  = (m_cnt + 1) % (1 << CNT_W);
                if (!link_op) begin
                    m_frame = trn_frm; m_src = SRC_TRN; m_run = 0;
                end else if (req && m_run < MAX_CONSEC_DATA) begin
                    m_frame = data_frm; m_src = SRC_DATA; m_ack = 1'b1; m_run++;
                end else begin
                    m_frame = dflt_frm; m_src = SRC_DFLT; m_run = 0;
                end
            end
            m_prev = int'(tx_off);
        end
    end

    // ---------------- stimulus helpers ----------------
    int   req_mode = 0;   // 0 random, 1 always requesting, 2 manual
    int   n_ticks  = 0;
    logic dut_wrap = 1'b0;

    function automatic LTPI_base_Frm_t rand_frm();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return LTPI_base_Frm_t'(r[119:0]);
    endfunction

    task automatic cycle();
        @(negedge clk);
        check("frame", frame_tx, m_frame);
        check("src",   src,      m_src);
        check("ack",   ack,      m_ack);
        check("tick",  tick,     m_tick);
        check("cnt",   cnt,      m_cnt);
        if (tick) n_ticks++;
        if (tick && cnt == '0) dut_wrap = 1'b1;
        // Source frames change freely mid-frame; only boundary values count.
        if ($urandom_range(0, 3) == 0) trn_frm  = rand_frm();
        if ($urandom_range(0, 3) == 0) dflt_frm = rand_frm();
        // Requester: holds req/data until the ack cycle.
        if (req && m_ack) begin
            if (req_mode == 1 || (req_mode == 0 && $urandom_range(0, 1) == 1)) begin
                data_frm = rand_frm();
                req      = 1'b1;
            end else begin
                req = 1'b0;
            end
        end else if (!req) begin
            if (req_mode == 1 || (req_mode == 0 && $urandom_range(0, 7) == 0)) begin
                data_frm = rand_frm();
                req      = 1'b1;
            end
        end else if (req_mode == 0 && $urandom_range(0, 31) == 0) begin
            req = 1'b0;   // abandoned request, never served
        end
    endtask

    // Walk whole frames; optionally change link_op when a given offset starts.
    task automatic run_frames(input int n, input int cpo, input int lo_at, input logic lo_val);
        for (int f = 0; f < n; f++) begin
            for (int o = 0; o < 16; o++) begin
                tx_off = 4'(o);
                if (o == lo_at) link_op = lo_val;
                repeat (cpo) cycle();
            end
        end
    endtask

    initial begin
        int t0;

        // Reset state
        repeat (3) cycle();
        check("rst_src", src, SRC_NONE);
        check("rst_cnt", cnt, 0);
        reset = 1'b0;

        // Training, 3 clk per offset
        link_op = 1'b0;
        run_frames(3, 3, -1, 1'b0);
        check("trn_src", src, SRC_TRN);
        check("trn_cnt", cnt, 3);

        // Offset held at 15 for 20 cycles -> one tick
        tx_off = 4'd14; repeat (3) cycle();
        tx_off = 4'd15;
        t0 = n_ticks;
        repeat (20) cycle();
        check("hold_ticks", n_ticks - t0, 1);

        // Operational with a permanently requesting data channel
        req_mode = 1;
        link_op  = 1'b1;
        run_frames(12, 2, -1, 1'b1);

        // Link drops mid-frame with request pending, then returns
        run_frames(1, 3, 7, 1'b0);
        check("lo_src", src, SRC_TRN);
        run_frames(1, 2, 7, 1'b1);
        run_frames(2, 2, -1, 1'b1);
        check("lo_back_src", src, SRC_DATA);

        // Request raised then dropped before the boundary
        req_mode = 2;
        req      = 1'b0;
        run_frames(1, 2, -1, 1'b1);
        for (int o = 0; o < 16; o++) begin
            tx_off = 4'(o);
            if (o == 4) begin data_frm = rand_frm(); req = 1'b1; end
            if (o == 10) req = 1'b0;
            repeat (2) cycle();
        end
        check("drop_src", src, SRC_DFLT);

        // Random mix of link state, request traffic and offset pacing
        req_mode = 0;
        for (int f = 0; f < 60; f++)
            run_frames(1, $urandom_range(2, 4), $urandom_range(0, 15),
                       ($urandom_range(0, 3) != 0));

        // Run to counter wrap, then reset mid-frame
        link_op  = 1'b1;
        req_mode = 1;
        for (int f = 0; f < 300 && !dut_wrap; f++) run_frames(1, 2, -1, 1'b1);
        check("wrap_seen", dut_wrap, 1'b1);
        run_frames(1, 2, -1, 1'b1);
        tx_off = 4'd3; repeat (2) cycle();
        reset = 1'b1;
        cycle();
        check("mid_rst_cnt",   cnt,      0);
        check("mid_rst_src",   src,      SRC_NONE);
        check("mid_rst_frame", frame_tx, 0);
        check("mid_rst_ack",   ack,      0);

        // Reset released while offset already 15 -> no boundary until re-entry
        tx_off = 4'd15; repeat (2) cycle();
        reset = 1'b0;
        t0 = n_ticks;
        repeat (6) cycle();
        check("rel15_ticks", n_ticks - t0, 0);
        run_frames(2, 3, -1, 1'b1);
        check("post_rst_cnt", cnt, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_ltpi_tx_frm_scheduler

// File: doc/ltpi_tx_frm_scheduler.md
Name: ltpi_tx_frm_scheduler

Overview:
- Frame-level scheduler in front of ltpi_phy_tx. Selects, once per LTPI frame, which source frame drives ltpi_frame_tx: the link-training frame, the default operational (I/O) frame, or a data-channel frame.
- Frame boundaries come from the PHY's tx_frm_offset. The output frame is updated only at the boundary, so it is stable while the PHY serialises offsets 0..14.
- Data-channel frames use a req/ack handshake. A starvation guard guarantees periodic default I/O frames.

Parameters:
MAX_CONSEC_DATA, 4, max back-to-back data frames before one default frame is forced; legal 1..15
CNT_W, 16, width of sent-frame counter

Ports:
clk  in  1  system clock (same clock as ltpi_phy_tx clk)
reset  in  1  synchronous, active-high reset
tx_frm_offset  in  4  frame byte offset from ltpi_phy_tx
link_op  in  1  1 = link operational, 0 = training
trn_frm  in  LTPI_base_Frm_t  training frame content
dflt_frm  in  LTPI_base_Frm_t  default operational I/O frame content
data_frm  in  LTPI_base_Frm_t  data-channel frame; stable while data_frm_req=1
data_frm_req  in  1  level request; held until ack
data_frm_ack  out  1  one-cycle pulse: data_frm has been latched
ltpi_frame_tx  out  LTPI_base_Frm_t  frame to ltpi_phy_tx
frm_src  out  2  source of current ltpi_frame_tx (frm_src_t)
frm_tick  out  1  one-cycle pulse per boundary
tx_frm_cnt  out  CNT_W  count of boundaries taken since reset

Behaviour:
- Reset values: ltpi_frame_tx all zeros, frm_src=SRC_NONE, data_frm_ack=0, frm_tick=0, tx_frm_cnt=0, consec_cnt=0, state=WAIT_SYNC.
- Boundary detection:
  - Register tx_frm_offset into offs_ff.
  - bnd = (tx_frm_offset==4'hF) && (offs_ff!=4'hF), with offs_ff reset to 4'hF.
  - Exactly one bnd per entry into offset 15, regardless of how long offset 15 is held.
- Update latency:
  - On the edge after the bnd cycle, ltpi_frame_tx, frm_src, frm_tick=1 and tx_frm_cnt+1 update together.
  - The result is valid from the 2nd cycle of offset 15. This requires PHY counter_offset_max >= 2, which holds for every supported speed.
- FSM: WAIT_SYNC, TRAINING, OPERATIONAL. Transitions occur only on bnd; link_op is sampled only in the bnd cycle.
  - WAIT_SYNC --bnd--> TRAINING if link_op=0, else OPERATIONAL. The frame chosen at that bnd follows the destination state.
  - TRAINING: every bnd latches trn_frm, frm_src=SRC_TRN, consec_cnt=0. If link_op=1 at bnd, go to OPERATIONAL and apply the OPERATIONAL selection at that same bnd.
  - OPERATIONAL: if link_op=0 at bnd, go to TRAINING and latch trn_frm. A pending data_frm_req is not acked.
- OPERATIONAL selection at bnd:
  - If data_frm_req=1 and consec_cnt<MAX_CONSEC_DATA: latch data_frm, frm_src=SRC_DATA, data_frm_ack=1 (single cycle), consec_cnt+1.
  - Otherwise: latch dflt_frm, frm_src=SRC_DFLT, consec_cnt=0.
- Handshake rules:
  - Requester drops or changes req/data_frm no earlier than the cycle after ack.
  - A req that is deasserted before a bnd is simply never served.
  - At most one ack per bnd.
- Wrap rules: tx_frm_cnt wraps all-ones -> 0. consec_cnt never exceeds MAX_CONSEC_DATA.
- Between boundaries, ltpi_frame_tx is held: input frame changes are not propagated.
- Reset mid-frame: all outputs return to reset values on the next edge, and the FSM re-enters WAIT_SYNC. The first frame after reset is taken at the next offset-15 entry. Since offs_ff resets to F, a reset released while offset is already 15 produces no bnd until the next entry.

Decomposition:
- ltpi_pkg additions:
  - typedef enum logic[1:0] frm_src_t {SRC_NONE=0, SRC_TRN=1, SRC_DFLT=2, SRC_DATA=3}
  - typedef enum sched_state_t {WAIT_SYNC, TRAINING, OPERATIONAL}
  - localparam FRM_LAST_OFFSET=4'hF
- LTPI_base_Frm_t is reused unchanged.
- No sub-module. Boundary detect, FSM and selection mux sit in one module.

Test Plan:
- Reset, link_op=0, PHY offsets cycling at 3 clk/offset -> first bnd at first offset-15 entry; frm_src=SRC_TRN, frm_tick one cycle, tx_frm_cnt=1; ltpi_frame_tx==trn_frm and unchanged while trn_frm is toggled mid-frame.
- Offset held at 15 for 20 cycles -> exactly one frm_tick, tx_frm_cnt increments by 1.
- link_op=1, data_frm_req held high continuously, MAX_CONSEC_DATA=4 -> frm_src sequence DATA,DATA,DATA,DATA,DFLT,DATA...; ack pulses only on DATA frames; each latched frame equals the data_frm presented.
- link_op 1->0 raised mid-frame with req pending -> no change until next bnd; at bnd frm_src=SRC_TRN, no ack; req still high is served after link_op returns to 1.
- req asserted then dropped before bnd -> no ack, frm_src=SRC_DFLT.
- Reset asserted mid-frame while OPERATIONAL with tx_frm_cnt preset near 16'hFFFF -> all outputs zero next edge; before reset, wrap FFFF->0 checked with frm_tick still pulsing.
